// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
   typedef enum logic {REQ_IF, REQ_D} requester_t;

   localparam int DEFAULT_MAX_WAIT = 15;

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating transaction-age counter; flags the cycle it reaches MAX_WAIT and the value itself.
module mem_arb_timeout
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expiring,
   output logic expired
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   // expiring marks the edge on which the count becomes MAX_WAIT, so the
   // timeout response appears exactly MAX_WAIT cycles after m_req rose.
   assign expiring = en && (count == (LIMIT - 1'b1));
   assign expired  = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store requesters with timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int B_WIDTH  = 32,
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [B_WIDTH-1:0]   if_addr,
   output logic                 if_gnt,
   output logic                 if_rvalid,
   output logic [B_WIDTH-1:0]   if_rdata,
   output logic                 if_err,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [B_WIDTH/8-1:0] d_be,
   input  logic [B_WIDTH-1:0]   d_addr,
   input  logic [B_WIDTH-1:0]   d_wdata,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [B_WIDTH-1:0]   d_rdata,
   output logic                 d_err,
   output logic                 m_req,
   output logic                 m_we,
   output logic [B_WIDTH/8-1:0] m_be,
   output logic [B_WIDTH-1:0]   m_addr,
   output logic [B_WIDTH-1:0]   m_wdata,
   input  logic                 m_gnt,
   input  logic                 m_rvalid,
   input  logic [B_WIDTH-1:0]   m_rdata
);

   arb_state_t         state;
   requester_t         owner;
   requester_t         winner;
   logic               grant;
   logic               busy;
   logic               expiring;
   logic               expired;
   logic               timeout;
   logic               done;
   logic               done_err;
   logic [B_WIDTH-1:0] rdata_q;

`ifdef MEM_ARB_RR_EN
   requester_t last_owner;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner <= REQ_IF;
      end else if (grant) begin
         last_owner <= winner;
      end
   end

   always_comb begin
      winner = REQ_IF;
      if (d_req && if_req) begin
         winner = (last_owner == REQ_IF) ? REQ_D : REQ_IF;
      end else if (d_req) begin
         winner = REQ_D;
      end
   end
`else
   always_comb begin
      winner = REQ_IF;
      if (d_req) begin
         winner = REQ_D;
      end
   end
`endif

   // Grant is combinational so the requester sees it in the cycle it asks;
   // gating with rst keeps every output low while reset is held.
   assign grant  = rst && (state == IDLE) && (if_req || d_req);
   assign if_gnt = grant && (winner == REQ_IF);
   assign d_gnt  = grant && (winner == REQ_D);

   assign busy = (state == REQ) || (state == WAIT);

   mem_arb_timeout #(.MAX_WAIT(MAX_WAIT)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == IDLE),
      .en       (busy),
      .expiring (expiring),
      .expired  (expired)
   );

   assign timeout  = busy && (expiring || expired);
   // A completion landing on the expiry edge takes precedence over the error.
   assign done     = ((state == WAIT) && m_rvalid) || timeout;
   assign done_err = !((state == WAIT) && m_rvalid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= REQ_IF;
         m_req     <= 1'b0;
         m_we      <= 1'b0;
         m_be      <= '0;
         m_addr    <= '0;
         m_wdata   <= '0;
         if_rvalid <= 1'b0;
         if_err    <= 1'b0;
         d_rvalid  <= 1'b0;
         d_err     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         if_err    <= 1'b0;
         d_rvalid  <= 1'b0;
         d_err     <= 1'b0;
         if (done) begin
            state     <= IDLE;
            m_req     <= 1'b0;
            if_rvalid <= (owner == REQ_IF);
            d_rvalid  <= (owner == REQ_D);
            if_err    <= done_err && (owner == REQ_IF);
            d_err     <= done_err && (owner == REQ_D);
            rdata_q   <= done_err ? '0 : m_rdata;
         end else begin
            case (state)
               IDLE: begin
                  if (grant) begin
                     state <= REQ;
                     owner <= winner;
                     m_req <= 1'b1;
                     if (winner == REQ_D) begin
                        m_we    <= d_we;
                        m_be    <= d_be;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                     end else begin
                        m_we    <= 1'b0;
                        m_be    <= '1;
                        m_addr  <= {if_addr[B_WIDTH-1:2], 2'b00};
                        m_wdata <= '0;
                     end
                  end
               end
               REQ: begin
                  if (m_gnt) begin
                     state <= WAIT;
                     m_req <= 1'b0;
                  end
               end
               WAIT: begin
                  state <= WAIT;
               end
               default: begin
                  state <= IDLE;
                  m_req <= 1'b0;
               end
            endcase
         end
      end
   end

   assign if_rdata = rdata_q;
   assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timing model.
module tb_mem_arbiter;

   localparam int BW = 32;
   localparam int MW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [BW-1:0] if_addr;
   logic          if_gnt, if_rvalid, if_err;
   logic [BW-1:0] if_rdata;
   logic          d_req, d_we;
   logic [3:0]    d_be;
   logic [BW-1:0] d_addr, d_wdata;
   logic          d_gnt, d_rvalid, d_err;
   logic [BW-1:0] d_rdata;
   logic          m_req, m_we;
   logic [3:0]    m_be;
   logic [BW-1:0] m_addr, m_wdata;
   logic          m_gnt, m_rvalid;
   logic [BW-1:0] m_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.B_WIDTH(BW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one outstanding transaction described by its key cycles.
   int            k = 0;
   bit            busy = 0;
   int            owner, R, G, V, C;
   bit            t_err, t_we;
   logic [3:0]    t_be;
   logic [BW-1:0] t_addr, t_wdata, t_data;
   bit            if_pend = 0, d_pend = 0;
   int            last_owner = 0;
   bit            gen_en = 0, force_stray = 0, force_rd_en = 0;
   int            force_g = -1, force_w = -1;
   logic [BW-1:0] force_rd = '0;

   task automatic start_txn(input int win);
      int g, w;
      busy  = 1;
      owner = win;
      R     = k + 1;
      if (win == 0) begin
         t_we = 0; t_be = 4'hF; t_addr = if_addr & ~32'h3; if_pend = 0;
      end else begin
         t_we = d_we; t_be = d_be; t_addr = d_addr; t_wdata = d_wdata; d_pend = 0;
      end
      last_owner = win;
      g = (force_g >= 0) ? force_g : int'($urandom_range(0, MW + 2));
      if (force_w >= 0) w = force_w;
      else if ($urandom_range(0, 3) == 0 && g <= MW - 2) w = MW - 2 - g;
      else w = int'($urandom_range(0, MW));
      G = R + g;
      V = G + 1 + w;
      if (G <= R + MW - 1 && V <= R + MW - 1) begin
         C = V + 1; t_err = 0;
      end else begin
         C = R + MW; t_err = 1;
      end
   endtask

   task automatic step();
      bit e_mreq, free, stray_ok, fin;
      int win;
      @(negedge clk);
      e_mreq = busy && k >= R && k <= G && k < C;
      fin    = busy && k == C;
      check("m_req", 64'(m_req), 64'(e_mreq));
      if (e_mreq) begin
         check("m_addr", 64'(m_addr), 64'(t_addr));
         check("m_we", 64'(m_we), 64'(t_we));
         check("m_be", 64'(m_be), 64'(t_be));
         if (t_we) check("m_wdata", 64'(m_wdata), 64'(t_wdata));
      end
      check("if_rvalid", 64'(if_rvalid), 64'(fin && owner == 0));
      check("d_rvalid", 64'(d_rvalid), 64'(fin && owner == 1));
      if (fin && owner == 0) begin
         check("if_err", 64'(if_err), 64'(t_err));
         check("if_rdata", 64'(if_rdata), t_err ? 64'd0 : 64'(t_data));
      end
      if (fin && owner == 1) begin
         check("d_err", 64'(d_err), 64'(t_err));
         if (t_err || !t_we) check("d_rdata", 64'(d_rdata), t_err ? 64'd0 : 64'(t_data));
      end
      if (gen_en) begin
         if (!if_pend && $urandom_range(0, 3) == 0) begin
            if_pend = 1; if_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 3) == 0) begin
            d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end
      end
      if_req   = if_pend;
      d_req    = d_pend;
      m_rdata  = force_rd_en ? force_rd : $urandom;
      m_gnt    = busy && k == G && k < C;
      stray_ok = !busy || k <= G || k >= C;
      m_rvalid = (busy && k == V && k < C) ||
                 (stray_ok && (force_stray || (gen_en && $urandom_range(0, 7) == 0)));
      if (busy && k == V && k < C) t_data = m_rdata;
      #1;
      free = !busy || k >= C;
      win  = -1;
      if (free && (if_pend || d_pend)) begin
         if (if_pend && d_pend) begin
`ifdef MEM_ARB_RR_EN
            win = (last_owner == 0) ? 1 : 0;
`else
            win = 1;
`endif
         end else begin
            win = d_pend ? 1 : 0;
         end
      end
      check("if_gnt", 64'(if_gnt), 64'(win == 0));
      check("d_gnt", 64'(d_gnt), 64'(win == 1));
      if (free) busy = 0;
      if (win >= 0) start_txn(win);
      k++;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 64'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, m_req, m_we, m_be}), 64'd0);
      check({tag, "_m_addr"}, 64'(m_addr), 64'd0);
      check({tag, "_m_wdata"}, 64'(m_wdata), 64'd0);
      check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 0; if_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
      if_pend = 0; d_pend = 0; busy = 0; last_owner = 0;
      #1 check_quiet("reset");
      repeat (cycles) @(negedge clk);
      check_quiet("reset_hold");
      rst = 1;
   endtask

   initial begin
      rst = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
      d_addr = '0; d_wdata = '0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
      do_reset(2);

      // Aligned fetch with known instruction word.
      force_g = 0; force_w = 0; force_rd_en = 1; force_rd = 32'h0051_0093;
      if_pend = 1; if_addr = 32'h0000_0103;
      repeat (6) step();
      force_rd_en = 0;

      // Two simultaneous pairs of requests.
      for (int p = 0; p < 2; p++) begin
         if_pend = 1; if_addr = 32'h0000_0400 + 32'(p);
         d_pend = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
         repeat (10) step();
      end

      // Memory never grants: timeout error.
      force_g = MW + 5;
      d_pend = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0300;
      repeat (MW + 4) step();

      // Completion on the expiry cycle.
      force_g = 0; force_w = MW - 2;
      if_pend = 1; if_addr = 32'h0000_0800;
      repeat (MW + 4) step();

      // Reset while waiting, then a stray completion.
      force_g = 0; force_w = 100;
      if_pend = 1; if_addr = 32'h0000_0900;
      repeat (5) step();
      do_reset(1);
      force_stray = 1; step(); force_stray = 0;
      repeat (2) step();
      force_g = 0; force_w = 0;
      if_pend = 1; if_addr = 32'h0000_0A04;
      repeat (6) step();

      // Random traffic.
      force_g = -1; force_w = -1; gen_en = 1;
      repeat (3000) step();
      gen_en = 0;
      repeat (3 * MW) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
